arbiter_match_ctrl: RTL and testbench

Best-of-N match sequencer for the two-player reaction game. It runs repeated rounds of the countdown/arbitration sequence and owns the countdown reset. It arbitrates the two player requests, with round-robin tie-breaking and false-start (foul) detection, and keeps both scores. It declares a match winner once a player reaches `WIN_SCORE`. It sits between the debounced, active-high player requests and the countdown/winner display blocks, and replaces the single-round FSM when the top level runs in match mode.

---
 rtl/arbiter_match_ctrl.sv | 297 +++++++++++++++++++++++++++++
 tb/tb_arbiter_match_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/arbiter_match_ctrl.sv
// ----------------------------------------------------------------------------
// arbiter_match_ctrl
//
// Best-of-N match sequencer for the two-player reaction game. Runs repeated
// rounds of release / countdown / armed / result, owns the countdown block's
// reset, arbitrates the two player requests (round-robin on exact ties),
// detects false starts during the countdown, keeps both scores and declares a
// match winner once a player reaches WIN_SCORE.
//
// Ports:
//   clk              - system clock, all state on the rising edge
//   reset            - synchronous, active-high reset
//   req1, req2       - debounced, active-high player requests
//   cd_done          - countdown finished (level, held until cd_rst_out rises)
//   cd_rst_out       - holds the countdown block in reset while high
//   gnt1_out         - player 1 won the round (valid in RESULT / MATCH_OVER)
//   gnt2_out         - player 2 won the round (valid in RESULT / MATCH_OVER)
//   foul1_out        - player 1 pressed during the countdown (valid in RESULT)
//   foul2_out        - player 2 pressed during the countdown (valid in RESULT)
//   round_done_out   - one-cycle pulse in the first RESULT cycle
//   score1_out       - player 1 score
//   score2_out       - player 2 score
//   match_winner_out - 00 none, 01 player 1, 10 player 2; sticky until reset
//
// All outputs come straight from flops; there is no input-to-output
// combinational path.
// ----------------------------------------------------------------------------
module arbiter_match_ctrl #(
    parameter int unsigned CLOCK_FREQ    = 12000000,
    parameter int unsigned WIN_SCORE     = 3,
    parameter int unsigned SCORE_W       = $clog2(WIN_SCORE + 1),
    parameter int unsigned REACT_TIMEOUT = CLOCK_FREQ * 3,
    parameter int unsigned RESULT_HOLD   = CLOCK_FREQ
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req1,
    input  logic               req2,
    input  logic               cd_done,
    output logic               cd_rst_out,
    output logic               gnt1_out,
    output logic               gnt2_out,
    output logic               foul1_out,
    output logic               foul2_out,
    output logic               round_done_out,
    output logic [SCORE_W-1:0] score1_out,
    output logic [SCORE_W-1:0] score2_out,
    output logic [1:0]         match_winner_out
);

    // One timer is shared between ARMED (reaction window) and RESULT (hold),
    // so it is sized for the longer of the two. It only ever counts to N-1.
    localparam int unsigned TimerMax = (REACT_TIMEOUT > RESULT_HOLD) ? REACT_TIMEOUT
                                                                      : RESULT_HOLD;
    localparam int unsigned TimerW   = (TimerMax > 1) ? $clog2(TimerMax) : 1;

    localparam logic [TimerW-1:0]  ReactLast = TimerW'(REACT_TIMEOUT - 1);
    localparam logic [TimerW-1:0]  HoldLast  = TimerW'(RESULT_HOLD - 1);
    localparam logic [SCORE_W-1:0] WinScore  = SCORE_W'(WIN_SCORE);

    typedef enum logic [2:0] {
        StIdle,
        StRelease,
        StCountdown,
        StArmed,
        StResult,
        StMatchOver
    } state_e;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_e             state_q, state_d;
    logic [TimerW-1:0]  timer_q, timer_d;
    logic               prio_q, prio_d;          // 0: player 1 wins ties, 1: player 2
    logic               cd_rst_q, cd_rst_d;
    logic               gnt1_q, gnt1_d;
    logic               gnt2_q, gnt2_d;
    logic               foul1_q, foul1_d;
    logic               foul2_q, foul2_d;
    logic               round_done_q, round_done_d;
    logic [SCORE_W-1:0] score1_q, score1_d;
    logic [SCORE_W-1:0] score2_q, score2_d;
    logic [1:0]         winner_q, winner_d;

    // ------------------------------------------------------------------------
    // Round outcome decode
    //
    // Resolves what the current cycle means for the round: who (if anyone)
    // takes the point, who fouled, and whether the round ends here. Only
    // COUNTDOWN and ARMED can resolve a round.
    // ------------------------------------------------------------------------
    logic resolve;     // round ends this cycle, enter RESULT
    logic win1;        // player 1 takes the point
    logic win2;        // player 2 takes the point
    logic early1;      // player 1 false start
    logic early2;      // player 2 false start
    logic tie;         // simultaneous press in ARMED, consumes the priority pointer

    always_comb begin
        resolve = 1'b0;
        win1    = 1'b0;
        win2    = 1'b0;
        early1  = 1'b0;
        early2  = 1'b0;
        tie     = 1'b0;

        case (state_q)
            StCountdown: begin
                if (req1 && req2) begin
                    // Double false start: nobody scores.
                    resolve = 1'b1;
                    early1  = 1'b1;
                    early2  = 1'b1;
                end else if (req1) begin
                    resolve = 1'b1;
                    early1  = 1'b1;
                    win2    = 1'b1;
                end else if (req2) begin
                    resolve = 1'b1;
                    early2  = 1'b1;
                    win1    = 1'b1;
                end
            end

            StArmed: begin
                // Requests are checked before the timeout so that a press in
                // the final window cycle still counts.
                if (req1 && req2) begin
                    resolve = 1'b1;
                    tie     = 1'b1;
                    win1    = ~prio_q;
                    win2    = prio_q;
                end else if (req1) begin
                    resolve = 1'b1;
                    win1    = 1'b1;
                end else if (req2) begin
                    resolve = 1'b1;
                    win2    = 1'b1;
                end else if (timer_q == ReactLast) begin
                    // Void round: no grant, no score change.
                    resolve = 1'b1;
                end
            end

            default: begin
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        prio_d       = prio_q;
        cd_rst_d     = cd_rst_q;
        gnt1_d       = gnt1_q;
        gnt2_d       = gnt2_q;
        foul1_d      = foul1_q;
        foul2_d      = foul2_q;
        round_done_d = 1'b0;
        score1_d     = score1_q;
        score2_d     = score2_q;
        winner_d     = winner_q;

        case (state_q)
            StIdle: begin
                state_d  = StRelease;
                cd_rst_d = 1'b1;
            end

            StRelease: begin
                // A button still held from the previous round keeps the
                // countdown parked in reset.
                cd_rst_d = 1'b1;
                if (!req1 && !req2) begin
                    state_d  = StCountdown;
                    cd_rst_d = 1'b0;
                end
            end

            StCountdown: begin
                cd_rst_d = 1'b0;
                if (!resolve && cd_done) begin
                    state_d = StArmed;
                    timer_d = '0;
                end
            end

            StArmed: begin
                cd_rst_d = 1'b0;
                timer_d  = timer_q + 1'b1;
            end

            StResult: begin
                cd_rst_d = 1'b1;
                timer_d  = timer_q + 1'b1;
                if (timer_q == HoldLast) begin
                    timer_d = '0;
                    if (score1_q == WinScore || score2_q == WinScore) begin
                        // Grant stays up to show the deciding round.
                        state_d  = StMatchOver;
                        foul1_d  = 1'b0;
                        foul2_d  = 1'b0;
                        winner_d = (score1_q == WinScore) ? 2'b01 : 2'b10;
                    end else begin
                        state_d = StRelease;
                        gnt1_d  = 1'b0;
                        gnt2_d  = 1'b0;
                        foul1_d = 1'b0;
                        foul2_d = 1'b0;
                    end
                end
            end

            StMatchOver: begin
                cd_rst_d = 1'b1;
            end

            default: begin
                state_d  = StIdle;
                cd_rst_d = 1'b1;
            end
        endcase

        // Common round resolution, shared by COUNTDOWN and ARMED.
        if (resolve) begin
            state_d      = StResult;
            timer_d      = '0;
            cd_rst_d     = 1'b1;
            round_done_d = 1'b1;
            gnt1_d       = win1;
            gnt2_d       = win2;
            foul1_d      = early1;
            foul2_d      = early2;
            // Scores saturate at WIN_SCORE.
            if (win1 && score1_q != WinScore) begin
                score1_d = score1_q + 1'b1;
            end
            if (win2 && score2_q != WinScore) begin
                score2_d = score2_q + 1'b1;
            end
            if (tie) begin
                prio_d = ~prio_q;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            timer_q      <= '0;
            prio_q       <= 1'b0;
            cd_rst_q     <= 1'b1;
            gnt1_q       <= 1'b0;
            gnt2_q       <= 1'b0;
            foul1_q      <= 1'b0;
            foul2_q      <= 1'b0;
            round_done_q <= 1'b0;
            score1_q     <= '0;
            score2_q     <= '0;
            winner_q     <= 2'b00;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            prio_q       <= prio_d;
            cd_rst_q     <= cd_rst_d;
            gnt1_q       <= gnt1_d;
            gnt2_q       <= gnt2_d;
            foul1_q      <= foul1_d;
            foul2_q      <= foul2_d;
            round_done_q <= round_done_d;
            score1_q     <= score1_d;
            score2_q     <= score2_d;
            winner_q     <= winner_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign cd_rst_out       = cd_rst_q;
    assign gnt1_out         = gnt1_q;
    assign gnt2_out         = gnt2_q;
    assign foul1_out        = foul1_q;
    assign foul2_out        = foul2_q;
    assign round_done_out   = round_done_q;
    assign score1_out       = score1_q;
    assign score2_out       = score2_q;
    assign match_winner_out = winner_q;

endmodule

// File: tb/tb_arbiter_match_ctrl.sv
// ----------------------------------------------------------------------------
// tb_arbiter_match_ctrl
//
// Directed bench for arbiter_match_ctrl with WIN_SCORE=2, RESULT_HOLD=4,
// REACT_TIMEOUT=10. The countdown block is modelled as cd_done rising five
// cycles after cd_rst_out falls and clearing when cd_rst_out is high.
// Inputs change and outputs are sampled on the falling clock edge.
// ----------------------------------------------------------------------------
module tb_arbiter_match_ctrl;

    localparam int unsigned Win  = 2;
    localparam int unsigned Hold = 4;
    localparam int unsigned Tmo  = 10;
    localparam int unsigned SW   = $clog2(Win + 1);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req1 = 1'b0;
    logic          req2 = 1'b0;
    logic          cd_done;
    logic          cd_rst_out;
    logic          gnt1_out;
    logic          gnt2_out;
    logic          foul1_out;
    logic          foul2_out;
    logic          round_done_out;
    logic [SW-1:0] score1_out;
    logic [SW-1:0] score2_out;
    logic [1:0]    match_winner_out;

    int n_cmp = 0;
    int n_bad = 0;
    int cd_cnt;

    arbiter_match_ctrl #(
        .CLOCK_FREQ   (12000000),
        .WIN_SCORE    (Win),
        .SCORE_W      (SW),
        .REACT_TIMEOUT(Tmo),
        .RESULT_HOLD  (Hold)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .req1            (req1),
        .req2            (req2),
        .cd_done         (cd_done),
        .cd_rst_out      (cd_rst_out),
        .gnt1_out        (gnt1_out),
        .gnt2_out        (gnt2_out),
        .foul1_out       (foul1_out),
        .foul2_out       (foul2_out),
        .round_done_out  (round_done_out),
        .score1_out      (score1_out),
        .score2_out      (score2_out),
        .match_winner_out(match_winner_out)
    );

    always #5 clk = ~clk;

    // Countdown block model.
    always @(posedge clk) begin
        if (reset || cd_rst_out) begin
            cd_cnt  <= 0;
            cd_done <= 1'b0;
        end else if (cd_cnt == 4) begin
            cd_done <= 1'b1;
        end else begin
            cd_cnt <= cd_cnt + 1;
        end
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic check_outs(input string tag, input int g1, input int g2, input int f1,
                              input int f2, input int rd, input int cdr, input int s1,
                              input int s2, input int mw);
        check_eq({tag, ".gnt1"}, int'(gnt1_out), g1);
        check_eq({tag, ".gnt2"}, int'(gnt2_out), g2);
        check_eq({tag, ".foul1"}, int'(foul1_out), f1);
        check_eq({tag, ".foul2"}, int'(foul2_out), f2);
        check_eq({tag, ".round_done"}, int'(round_done_out), rd);
        check_eq({tag, ".cd_rst"}, int'(cd_rst_out), cdr);
        check_eq({tag, ".score1"}, int'(score1_out), s1);
        check_eq({tag, ".score2"}, int'(score2_out), s2);
        check_eq({tag, ".winner"}, int'(match_winner_out), mw);
    endtask

    // One edge with reset high, then reset values are expected.
    task automatic do_reset(input string tag);
        reset = 1'b1;
        req1  = 1'b0;
        req2  = 1'b0;
        tick();
        check_outs(tag, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        reset = 1'b0;
    endtask

    // Returns in the first COUNTDOWN cycle.
    task automatic wait_countdown();
        for (int i = 0; i < 40 && cd_rst_out; i++) tick();
        check_eq("wait_countdown", int'(cd_rst_out), 0);
    endtask

    // Returns in the first ARMED cycle.
    task automatic wait_armed();
        wait_countdown();
        for (int i = 0; i < 40 && !cd_done; i++) tick();
        check_eq("wait_cd_done", int'(cd_done), 1);
        tick();
    endtask

    // Called in the first RESULT cycle; walks the remaining hold cycles and
    // checks the cycle after RESULT (RELEASE, or MATCH_OVER when over=1).
    task automatic finish_result(input string tag, input int g1, input int g2, input int f1,
                                 input int f2, input int s1, input int s2, input int over,
                                 input int mw);
        for (int i = 1; i < int'(Hold); i++) begin
            tick();
            check_outs({tag, ".hold"}, g1, g2, f1, f2, 0, 1, s1, s2, 0);
        end
        tick();
        if (over != 0) check_outs({tag, ".over"}, g1, g2, 0, 0, 0, 1, s1, s2, mw);
        else           check_outs({tag, ".after"}, 0, 0, 0, 0, 0, 1, s1, s2, 0);
    endtask

    initial begin
        // ---------------- Phase A: timeout round, then a clean player-1 win
        do_reset("rst_a");
        tick();
        check_eq("idle_release.cd_rst", int'(cd_rst_out), 1);
        tick();
        check_eq("countdown.cd_rst", int'(cd_rst_out), 0);

        wait_armed();
        for (int i = 1; i < int'(Tmo); i++) begin
            tick();
            check_eq("armed_wait.round_done", int'(round_done_out), 0);
        end
        tick();
        check_outs("timeout", 0, 0, 0, 0, 1, 1, 0, 0, 0);
        finish_result("timeout", 0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        check_eq("timeout.back_countdown", int'(cd_rst_out), 0);

        wait_armed();
        tick();
        tick();
        req1 = 1'b1;
        tick();
        req1 = 1'b0;
        check_outs("win1", 1, 0, 0, 0, 1, 1, 1, 0, 0);
        finish_result("win1", 1, 0, 0, 0, 1, 0, 0, 0);

        // ---------------- Phase B: fouls, held button, player 1 takes match
        do_reset("rst_b");
        wait_countdown();
        req1 = 1'b1;
        req2 = 1'b1;
        tick();
        req1 = 1'b0;
        req2 = 1'b0;
        check_outs("foul_both", 0, 0, 1, 1, 1, 1, 0, 0, 0);
        finish_result("foul_both", 0, 0, 1, 1, 0, 0, 0, 0);

        wait_countdown();
        req2 = 1'b1;
        tick();
        check_outs("foul2", 1, 0, 0, 1, 1, 1, 1, 0, 0);
        finish_result("foul2", 1, 0, 0, 1, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            tick();
            check_eq("stall.cd_rst", int'(cd_rst_out), 1);
        end
        req2 = 1'b0;
        tick();
        check_eq("unstall.cd_rst", int'(cd_rst_out), 0);

        wait_armed();
        req1 = 1'b1;
        tick();
        req1 = 1'b0;
        check_outs("match1", 1, 0, 0, 0, 1, 1, 2, 0, 0);
        finish_result("match1", 1, 0, 0, 0, 2, 0, 1, 1);

        req1 = 1'b1;
        tick();
        tick();
        req2 = 1'b1;
        tick();
        check_outs("over_both", 1, 0, 0, 0, 0, 1, 2, 0, 1);
        req1 = 1'b0;
        tick();
        req2 = 1'b0;
        tick();
        check_outs("over_idle", 1, 0, 0, 0, 0, 1, 2, 0, 1);

        // ---------------- Phase C: ties, last-cycle press, mid-ARMED reset
        do_reset("rst_c");
        wait_armed();
        req1 = 1'b1;
        req2 = 1'b1;
        tick();
        req1 = 1'b0;
        req2 = 1'b0;
        check_outs("tie_a", 1, 0, 0, 0, 1, 1, 1, 0, 0);
        finish_result("tie_a", 1, 0, 0, 0, 1, 0, 0, 0);

        // Press in the last window cycle beats the timeout.
        wait_armed();
        for (int i = 1; i < int'(Tmo); i++) tick();
        req2 = 1'b1;
        tick();
        req2 = 1'b0;
        check_outs("late2", 0, 1, 0, 0, 1, 1, 1, 1, 0);
        finish_result("late2", 0, 1, 0, 0, 1, 1, 0, 0);

        wait_armed();
        tick();
        tick();
        do_reset("mid_armed_rst");

        // Priority back at player 1 after reset.
        wait_armed();
        req1 = 1'b1;
        req2 = 1'b1;
        tick();
        req1 = 1'b0;
        req2 = 1'b0;
        check_outs("tie_p1", 1, 0, 0, 0, 1, 1, 1, 0, 0);
        finish_result("tie_p1", 1, 0, 0, 0, 1, 0, 0, 0);

        // Single press must leave the pointer at player 2.
        wait_armed();
        req2 = 1'b1;
        tick();
        req2 = 1'b0;
        check_outs("solo2", 0, 1, 0, 0, 1, 1, 1, 1, 0);
        finish_result("solo2", 0, 1, 0, 0, 1, 1, 0, 0);

        wait_armed();
        req1 = 1'b1;
        req2 = 1'b1;
        tick();
        req1 = 1'b0;
        req2 = 1'b0;
        check_outs("tie_p2", 0, 1, 0, 0, 1, 1, 1, 2, 0);
        finish_result("tie_p2", 0, 1, 0, 0, 1, 2, 1, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, n_bad=%0d", n_bad);
        $fatal(1);
    end

endmodule
